// File: rtl/pc_ctrl.sv
`timescale 1ns/1ps
// pc_ctrl: MIPS fetch-stage sequencer.
// Owns the program counter and issues instruction ROM requests over a
// req/ack handshake that tolerates wait states. Applies hazard stalls
// through a one-entry skid buffer and handles taken branch/jump
// redirects. Fetched words reach IF/ID as a registered, valid-qualified
// stream.
module pc_ctrl #(
   parameter int unsigned                 INST_ADDR_WIDTH = 32,
   parameter int unsigned                 INST_WIDTH      = 32,
   parameter logic [INST_ADDR_WIDTH-1:0]  RESET_VECTOR    = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       stall_req,
   input  logic                       branch_taken,
   input  logic [INST_ADDR_WIDTH-1:0] branch_target,
   output logic                       rom_req,
   output logic [INST_ADDR_WIDTH-1:0] rom_addr,
   input  logic                       rom_ack,
   input  logic [INST_WIDTH-1:0]      rom_data,
   output logic                       if_valid,
   output logic [INST_ADDR_WIDTH-1:0] if_pc,
   output logic [INST_WIDTH-1:0]      if_inst,
   output logic                       flush
);

   // IDLE: one-cycle delay after reset. FETCH: request outstanding.
   // STALL: hazard hold, skid buffer empty. HOLD: hazard hold, buffer full.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_STALL = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   localparam logic [INST_ADDR_WIDTH-1:0] PC_STEP = INST_ADDR_WIDTH'(4);

   // Architectural state
   state_t                       r_state;
   logic [INST_ADDR_WIDTH-1:0]   r_pc;
   logic                         r_pend_valid;
   logic [INST_ADDR_WIDTH-1:0]   r_pend_target;

   // Skid buffer (its fullness is encoded by r_state == ST_HOLD)
   logic [INST_ADDR_WIDTH-1:0]   r_buf_pc;
   logic [INST_WIDTH-1:0]        r_buf_inst;

   // Registered IF/ID-facing outputs
   logic                         r_if_valid;
   logic [INST_ADDR_WIDTH-1:0]   r_if_pc;
   logic [INST_WIDTH-1:0]        r_if_inst;
   logic                         r_flush;

   // Next-state / control decode
   state_t                       w_state_nxt;
   logic [INST_ADDR_WIDTH-1:0]   w_pc_nxt;
   logic                         w_pend_valid_nxt;
   logic [INST_ADDR_WIDTH-1:0]   w_pend_target_nxt;
   logic                         w_buf_load;
   logic                         w_deliver;
   logic [INST_ADDR_WIDTH-1:0]   w_deliver_pc;
   logic [INST_WIDTH-1:0]        w_deliver_inst;
   logic [INST_ADDR_WIDTH-1:0]   w_target;
   logic [INST_ADDR_WIDTH-1:0]   w_pc_inc;
   state_t                       w_resume;

   // Instructions are word aligned, so the low two target bits are dropped.
   assign w_target = {branch_target[INST_ADDR_WIDTH-1:2], 2'b00};
   // Natural modulo 2^INST_ADDR_WIDTH wrap of the increment.
   assign w_pc_inc = r_pc + PC_STEP;
   // Where fetch resumes after a redirect or the reset delay.
   assign w_resume = stall_req ? ST_STALL : ST_FETCH;

   // Next-state, next-PC, pending-redirect and delivery decode.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can
      // leave one unassigned, which would otherwise infer a latch.
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_pend_valid_nxt  = r_pend_valid;
      w_pend_target_nxt = r_pend_target;
      w_buf_load        = 1'b0;
      w_deliver         = 1'b0;
      w_deliver_pc      = r_pc;
      w_deliver_inst    = rom_data;

      case (r_state)
         ST_IDLE: begin
            if (branch_taken) begin
               w_pc_nxt = w_target;
            end
            w_state_nxt = w_resume;
         end

         ST_STALL: begin
            if (branch_taken) begin
               w_pc_nxt = w_target;
            end
            w_state_nxt = w_resume;
         end

         ST_FETCH: begin
            if (rom_ack) begin
               // Request completes; any redirect consumes the returned word.
               w_pend_valid_nxt = 1'b0;
               if (branch_taken) begin
                  w_pc_nxt    = w_target;
                  w_state_nxt = w_resume;
               end else if (r_pend_valid) begin
                  w_pc_nxt    = r_pend_target;
                  w_state_nxt = w_resume;
               end else if (!stall_req) begin
                  w_deliver = 1'b1;
                  w_pc_nxt  = w_pc_inc;
               end else begin
                  w_buf_load  = 1'b1;
                  w_pc_nxt    = w_pc_inc;
                  w_state_nxt = ST_HOLD;
               end
            end else if (branch_taken) begin
               // Request stays stable on the ROM bus; remember the redirect
               // (a newer one overwrites an older one).
               w_pend_valid_nxt  = 1'b1;
               w_pend_target_nxt = w_target;
            end
         end

         ST_HOLD: begin
            if (branch_taken) begin
               // Buffered word belongs to the squashed path: drop it.
               w_pc_nxt    = w_target;
               w_state_nxt = w_resume;
            end else if (!stall_req) begin
               w_deliver      = 1'b1;
               w_deliver_pc   = r_buf_pc;
               w_deliver_inst = r_buf_inst;
               w_state_nxt    = ST_FETCH;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, PC and pending-redirect registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_pc          <= RESET_VECTOR;
         r_pend_valid  <= 1'b0;
         r_pend_target <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_pend_valid  <= w_pend_valid_nxt;
         r_pend_target <= w_pend_target_nxt;
      end
   end

   // Skid buffer capture when an ack lands while the hazard unit stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the buffer payload is qualified by ST_HOLD and strictly needs
      // no reset; it is cleared anyway so no X ever reaches if_pc/if_inst.
      if (!rst_n) begin
         r_buf_pc   <= '0;
         r_buf_inst <= '0;
      end else if (w_buf_load) begin
         r_buf_pc   <= r_pc;
         r_buf_inst <= rom_data;
      end
   end

   // Registered delivery to IF/ID: one-cycle valid pulse per instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_valid <= 1'b0;
         r_if_pc    <= '0;
         r_if_inst  <= '0;
      end else begin
         r_if_valid <= w_deliver;
         if (w_deliver) begin
            r_if_pc   <= w_deliver_pc;
            r_if_inst <= w_deliver_inst;
         end
      end
   end

   // Flush IF/ID the cycle after any taken redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flush <= 1'b0;
      end else begin
         r_flush <= branch_taken;
      end
   end

   // ROM interface is decoded from registered state only.
   assign rom_req  = (r_state == ST_FETCH);
   assign rom_addr = r_pc;

   assign if_valid = r_if_valid;
   assign if_pc    = r_if_pc;
   assign if_inst  = r_if_inst;
   assign flush    = r_flush;

endmodule

// File: tb/tb_pc_ctrl.sv
`timescale 1ns/1ps
// tb_pc_ctrl: directed stimulus for pc_ctrl with a behavioural ROM and a
// delivery scoreboard. Stimulus pushes each expected IF/ID delivery; a
// separate monitor pops and compares whenever if_valid is seen.
module tb_pc_ctrl;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } deliv_t;

   logic        clk;
   logic        rst_n;
   logic        stall_req;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        rom_req;
   logic [31:0] rom_addr;
   logic        rom_ack;
   logic [31:0] rom_data;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        flush;

   // ROM model controls
   int          wait_states;
   logic        rom_hold;
   logic        force_ack;
   int          rom_cnt;

   deliv_t      exp_q[$];
   int          n_total;
   int          n_bad;

   pc_ctrl #(
      .INST_ADDR_WIDTH (32),
      .INST_WIDTH      (32),
      .RESET_VECTOR    (32'h0)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_req     (stall_req),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .rom_req       (rom_req),
      .rom_addr      (rom_addr),
      .rom_ack       (rom_ack),
      .rom_data      (rom_data),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_inst       (if_inst),
      .flush         (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return a ^ 32'h5A5A_1234;
   endfunction

   // Behavioural ROM: acks after wait_states cycles of an outstanding request.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  rom_cnt <= 0;
      else if (rom_req && !rom_ack) rom_cnt <= rom_cnt + 1;
      else                         rom_cnt <= 0;
   end
   assign rom_ack  = force_ack | (rom_req && !rom_hold && (rom_cnt >= wait_states));
   assign rom_data = rom_word(rom_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [31:0] a);
      exp_q.push_back('{pc: a, inst: rom_word(a)});
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Returns 1ns into cycle 0 after release (DUT in IDLE).
   task automatic apply_reset();
      rst_n         = 1'b0;
      stall_req     = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      force_ack     = 1'b0;
      next_cycle();
      rom_hold = 1'b0;
      next_cycle();
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (rst_n && if_valid) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_valid", {31'b0, if_valid}, 32'h0);
         end else begin
            deliv_t e;
            e = exp_q.pop_front();
            check("sb_pc", if_pc, e.pc);
            check("sb_inst", if_inst, e.inst);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_total = 0; n_bad = 0;
      rst_n = 1'b1; stall_req = 1'b0; branch_taken = 1'b0; branch_target = '0;
      wait_states = 0; rom_hold = 1'b0; force_ack = 1'b0;

      // Reset values
      #2 rst_n = 1'b0;
      #1;
      check("rst_rom_req",  {31'b0, rom_req},  32'h0);
      check("rst_rom_addr", rom_addr,          32'h0);
      check("rst_if_valid", {31'b0, if_valid}, 32'h0);
      check("rst_flush",    {31'b0, flush},    32'h0);
      check("rst_if_pc",    if_pc,             32'h0);
      check("rst_if_inst",  if_inst,           32'h0);

      // S1: zero-wait streaming, then async reset during a wait
      apply_reset();
      check("s1_idle_req", {31'b0, rom_req}, 32'h0);
      push(32'h0); push(32'h4); push(32'h8);
      next_cycle();
      check("s1_c1_req",  {31'b0, rom_req}, 32'h1);
      check("s1_c1_addr", rom_addr, 32'h0);
      next_cycle();
      check("s1_c2_addr", rom_addr, 32'h4);
      next_cycle();
      check("s1_c3_addr", rom_addr, 32'h8);
      next_cycle();
      rom_hold = 1'b1;
      check("s1_c4_addr", rom_addr, 32'hC);
      next_cycle();
      check("s1_wait_req", {31'b0, rom_req}, 32'h1);
      rst_n = 1'b0; force_ack = 1'b1;
      #1;
      check("s1_async_req",  {31'b0, rom_req}, 32'h0);
      check("s1_async_addr", rom_addr, 32'h0);
      next_cycle();
      force_ack = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      check("s1_restart_c0_req", {31'b0, rom_req}, 32'h0);
      next_cycle();
      check("s1_restart_c1_req",  {31'b0, rom_req}, 32'h1);
      check("s1_restart_c1_addr", rom_addr, 32'h0);
      next_cycle();

      // S2: two wait states
      wait_states = 2;
      apply_reset();
      push(32'h0);
      for (int i = 1; i <= 3; i++) begin
         next_cycle();
         check("s2_addr_held", rom_addr, 32'h0);
         check("s2_req_held",  {31'b0, rom_req}, 32'h1);
      end
      next_cycle();
      check("s2_valid", {31'b0, if_valid}, 32'h1);
      check("s2_next_addr", rom_addr, 32'h4);
      rom_hold = 1'b1;
      next_cycle();
      wait_states = 0;
      next_cycle();

      // S3: stall at the ack of 8, held three cycles
      apply_reset();
      push(32'h0); push(32'h4); push(32'h8);
      next_cycle();
      next_cycle();
      next_cycle();
      stall_req = 1'b1;
      check("s3_ack_addr", rom_addr, 32'h8);
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         check("s3_hold_req",   {31'b0, rom_req},  32'h0);
         check("s3_hold_valid", {31'b0, if_valid}, 32'h0);
      end
      next_cycle();
      stall_req = 1'b0;
      check("s3_release_valid", {31'b0, if_valid}, 32'h0);
      next_cycle();
      check("s3_deliver_valid", {31'b0, if_valid}, 32'h1);
      check("s3_deliver_pc",    if_pc, 32'h8);
      check("s3_resume_req",    {31'b0, rom_req}, 32'h1);
      check("s3_resume_addr",   rom_addr, 32'hC);
      rom_hold = 1'b1;
      next_cycle();

      // S4: redirect one cycle before a late ack at 0x20
      apply_reset();
      rom_hold = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
      next_cycle();
      branch_taken = 1'b0;
      check("s4_c1_addr",  rom_addr, 32'h20);
      check("s4_c1_flush", {31'b0, flush}, 32'h1);
      next_cycle();
      branch_taken = 1'b1; branch_target = 32'h103;
      check("s4_c2_flush", {31'b0, flush}, 32'h0);
      next_cycle();
      branch_taken = 1'b0; rom_hold = 1'b0;
      check("s4_c3_addr",  rom_addr, 32'h20);
      check("s4_c3_flush", {31'b0, flush}, 32'h1);
      push(32'h100);
      next_cycle();
      check("s4_c4_addr",  rom_addr, 32'h100);
      check("s4_c4_flush", {31'b0, flush}, 32'h0);
      check("s4_c4_valid", {31'b0, if_valid}, 32'h0);
      next_cycle();
      rom_hold = 1'b1;
      next_cycle();

      // S5: redirect while HOLD with stall still asserted
      apply_reset();
      next_cycle();
      stall_req = 1'b1;
      next_cycle();
      branch_taken = 1'b1; branch_target = 32'h40;
      check("s5_hold_req", {31'b0, rom_req}, 32'h0);
      next_cycle();
      branch_taken = 1'b0;
      check("s5_flush",      {31'b0, flush},    32'h1);
      check("s5_stall_req",  {31'b0, rom_req},  32'h0);
      check("s5_stall_addr", rom_addr,          32'h40);
      check("s5_no_valid",   {31'b0, if_valid}, 32'h0);
      next_cycle();
      stall_req = 1'b0;
      check("s5_still_stall", {31'b0, rom_req}, 32'h0);
      push(32'h40);
      next_cycle();
      check("s5_fetch_req",  {31'b0, rom_req}, 32'h1);
      check("s5_fetch_addr", rom_addr, 32'h40);
      next_cycle();
      rom_hold = 1'b1;
      check("s5_valid", {31'b0, if_valid}, 32'h1);
      next_cycle();

      // S6: PC wrap, unaligned target masked
      apply_reset();
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
      next_cycle();
      branch_taken = 1'b0;
      check("s6_top_addr", rom_addr, 32'hFFFF_FFFC);
      push(32'hFFFF_FFFC);
      next_cycle();
      check("s6_wrap_addr", rom_addr, 32'h0);
      rom_hold = 1'b1;
      next_cycle();
      next_cycle();

      check("sb_drain", exp_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
